// File: rtl/mycpu_pkg.sv
// ============================================================================
// Module   : mycpu_pkg
// Brief    : Shared types and constants for the banked register file and its
//            context save/restore engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mycpu_pkg;

    typedef enum logic [1:0] {
        CTX_IDLE = 2'd0,
        CTX_COPY = 2'd1,
        CTX_DONE = 2'd2
    } rb_ctx_state_t;

    localparam logic CTX_OP_SAVE    = 1'b0;
    localparam logic CTX_OP_RESTORE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rb_ctx_fsm.sv
// ============================================================================
// Module   : rb_ctx_fsm
// Brief    : Context copy sequencer: walks the word index across one bank and
//            reports busy/done around the transfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rb_ctx_fsm
    import mycpu_pkg::*;
#(
    parameter int NREG = 8,
    localparam int IW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctx_req_in,
    input  logic          ctx_op_in,
    output logic          copy_en,
    output logic [IW-1:0] copy_idx,
    output logic          copy_dir,
    output logic          busy,
    output logic          done
);

    localparam logic [IW-1:0] C_LAST_IDX = IW'(NREG - 1);

    rb_ctx_state_t r_state;
    logic [IW-1:0] r_idx;
    logic          r_op;
    logic          r_copy_en;
    logic          r_busy;
    logic          r_done;

    // Outputs are registered alongside the state so they change only at edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CTX_IDLE;
            r_idx     <= '0;
            r_op      <= CTX_OP_SAVE;
            r_copy_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                CTX_IDLE: begin
                    if (ctx_req_in) begin
                        r_state   <= CTX_COPY;
                        r_op      <= ctx_op_in;
                        r_idx     <= '0;
                        r_copy_en <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                CTX_COPY: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == C_LAST_IDX) begin
                        r_state   <= CTX_DONE;
                        r_copy_en <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                CTX_DONE: begin
                    r_state <= CTX_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state   <= CTX_IDLE;
                    r_copy_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign copy_en  = r_copy_en;
    assign copy_idx = r_idx;
    assign copy_dir = r_op;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: rtl/rb_banked.sv
// ============================================================================
// Module   : rb_banked
// Brief    : User + hidden register banks with NRP combinational read ports,
//            optional write bypass / zero R0 and a bank-to-bank copy engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rb_banked
    import mycpu_pkg::*;
#(
    parameter int DW      = 16,
    parameter int NREG    = 8,
    parameter int NRP     = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREG) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     d_in,
    input  logic              rw_in,
    input  logic [AW-1:0]     wsel_in,
    input  logic [NRP*AW-1:0] rsel_in,
    output logic [NRP*DW-1:0] rd_out,
    input  logic              ctx_req_in,
    input  logic              ctx_op_in,
    output logic              ctx_busy_out,
    output logic              ctx_done_out
);

    localparam int IW = AW - 1;

    logic [DW-1:0] r_user   [NREG];
    logic [DW-1:0] r_hidden [NREG];

    logic          w_copy_en;
    logic [IW-1:0] w_copy_idx;
    logic          w_copy_dir;
    logic          w_busy;
    logic          w_wr_ok;
    logic          w_wr_hidden;
    logic [IW-1:0] w_wr_idx;
    logic          w_copy_to_r0;
    logic          w_wr_to_r0;

    rb_ctx_fsm #(
        .NREG (NREG)
    ) u_ctx_fsm (
        .clk        (clk),
        .rst        (rst),
        .ctx_req_in (ctx_req_in),
        .ctx_op_in  (ctx_op_in),
        .copy_en    (w_copy_en),
        .copy_idx   (w_copy_idx),
        .copy_dir   (w_copy_dir),
        .busy       (w_busy),
        .done       (ctx_done_out)
    );

    assign ctx_busy_out = w_busy;

    // External writes are only taken while the copy engine is idle.
    assign w_wr_ok      = rw_in && !w_busy;
    assign w_wr_hidden  = wsel_in[AW-1];
    assign w_wr_idx     = wsel_in[AW-2:0];
    assign w_copy_to_r0 = (ZERO_R0 != 0) && (w_copy_idx == '0);
    assign w_wr_to_r0   = (ZERO_R0 != 0) && !w_wr_hidden && (w_wr_idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_user[i]   <= '0;
                r_hidden[i] <= '0;
            end
        end else if (w_copy_en) begin
            if (w_copy_dir == CTX_OP_SAVE) begin
                r_hidden[w_copy_idx] <= r_user[w_copy_idx];
            end else if (!w_copy_to_r0) begin
                r_user[w_copy_idx] <= r_hidden[w_copy_idx];
            end
        end else if (w_wr_ok) begin
            if (w_wr_hidden) begin
                r_hidden[w_wr_idx] <= d_in;
            end else if (!w_wr_to_r0) begin
                r_user[w_wr_idx] <= d_in;
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] w_rsel;
        logic [DW-1:0] w_data;

        assign w_rsel = rsel_in[p*AW +: AW];

        // Zero-R0 is applied last so it overrides the bypass path.
        always_comb begin
            w_data = w_rsel[AW-1] ? r_hidden[w_rsel[AW-2:0]] : r_user[w_rsel[AW-2:0]];
            if ((BYPASS != 0) && w_wr_ok && (w_rsel == wsel_in)) begin
                w_data = d_in;
            end
            if ((ZERO_R0 != 0) && (w_rsel == '0)) begin
                w_data = '0;
            end
        end

        assign rd_out[p*DW +: DW] = w_data;
    end

endmodule

`default_nettype wire

// File: tb/tb_rb_banked.sv
// ============================================================================
// Module   : tb_rb_banked
// Brief    : Self-checking bench driving three configurations of rb_banked
//            (bypass, no bypass, bypass + zero R0) from one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rb_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d;
    logic        rw;
    logic [3:0]  wsel;
    logic [3:0]  rs0;
    logic [3:0]  rs1;
    logic        req;
    logic        op;

    logic [31:0] rd_b, rd_n, rd_z;
    logic        busy_b, busy_n, busy_z;
    logic        done_b, done_n, done_z;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rb_banked #(.DW(16), .NREG(8), .NRP(2), .BYPASS(1), .ZERO_R0(0)) dut_b (
        .clk(clk), .rst(rst), .d_in(d), .rw_in(rw), .wsel_in(wsel),
        .rsel_in({rs1, rs0}), .rd_out(rd_b), .ctx_req_in(req), .ctx_op_in(op),
        .ctx_busy_out(busy_b), .ctx_done_out(done_b));

    rb_banked #(.DW(16), .NREG(8), .NRP(2), .BYPASS(0), .ZERO_R0(0)) dut_n (
        .clk(clk), .rst(rst), .d_in(d), .rw_in(rw), .wsel_in(wsel),
        .rsel_in({rs1, rs0}), .rd_out(rd_n), .ctx_req_in(req), .ctx_op_in(op),
        .ctx_busy_out(busy_n), .ctx_done_out(done_n));

    rb_banked #(.DW(16), .NREG(8), .NRP(2), .BYPASS(1), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .d_in(d), .rw_in(rw), .wsel_in(wsel),
        .rsel_in({rs1, rs0}), .rd_out(rd_z), .ctx_req_in(req), .ctx_op_in(op),
        .ctx_busy_out(busy_z), .ctx_done_out(done_z));

    // Reference model: flat address space per config (0-7 user, 8-15 hidden),
    // plus a cycle counter for the copy (0 idle, 1..8 copying word n-1, 9 done).
    logic [15:0] mem [3][16];
    int          phase;
    logic        mop;
    logic        s_busy, s_done;

    function automatic bit cfg_bypass(int c); return c != 1; endfunction
    function automatic bit cfg_zero(int c);   return c == 2; endfunction

    function automatic logic [15:0] exp_rd(int c, logic [3:0] a);
        if (cfg_zero(c) && a == 4'd0) return 16'h0;
        if (cfg_bypass(c) && rw && phase == 0 && a == wsel) return d;
        return mem[c][a];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 16; a++) mem[c][a] = 16'h0;
        phase = 0;
        mop   = 1'b0;
    endtask

    task automatic model_edge();
        if (phase == 0) begin
            if (rw)
                for (int c = 0; c < 3; c++)
                    if (!(cfg_zero(c) && wsel == 4'd0)) mem[c][wsel] = d;
            if (req) begin
                mop   = op;
                phase = 1;
            end
        end else if (phase <= 8) begin
            for (int c = 0; c < 3; c++) begin
                if (!mop) mem[c][8 + phase - 1] = mem[c][phase - 1];
                else if (!(cfg_zero(c) && phase == 1)) mem[c][phase - 1] = mem[c][8 + phase - 1];
            end
            phase++;
        end else begin
            phase = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rd_b0", 32'(rd_b[15:0]),  32'(exp_rd(0, rs0)));
        chk("rd_b1", 32'(rd_b[31:16]), 32'(exp_rd(0, rs1)));
        chk("rd_n0", 32'(rd_n[15:0]),  32'(exp_rd(1, rs0)));
        chk("rd_n1", 32'(rd_n[31:16]), 32'(exp_rd(1, rs1)));
        chk("rd_z0", 32'(rd_z[15:0]),  32'(exp_rd(2, rs0)));
        chk("rd_z1", 32'(rd_z[31:16]), 32'(exp_rd(2, rs1)));
        chk("busy",  {29'd0, busy_b, busy_n, busy_z}, {29'd0, {3{phase != 0}}});
        chk("done",  {29'd0, done_b, done_n, done_z}, {29'd0, {3{phase == 9}}});
        s_busy = busy_b;
        s_done = done_b;
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cycle();
        sample();
        edge_step();
    endtask

    // Issues one request (rw/wsel/d as preset by caller apply on the same edge),
    // then runs the copy with an optional injected write/request at step inj_k.
    task automatic run_copy(input logic op_v, input int inj_k, input logic inj_rw,
                            input logic [3:0] inj_ws, input logic [15:0] inj_d,
                            input logic inj_req, output int nb, output int nd, output int dp);
        req = 1'b1;
        op  = op_v;
        cycle();
        req = 1'b0;
        rw  = 1'b0;
        nb = 0; nd = 0; dp = 0;
        for (int k = 1; k <= 12; k++) begin
            rs0 = 4'($urandom_range(0, 15));
            rs1 = 4'($urandom_range(0, 15));
            if (k == inj_k) begin
                rw   = inj_rw;
                wsel = inj_ws;
                d    = inj_d;
                req  = inj_req;
                op   = ~op_v;
            end
            cycle();
            rw  = 1'b0;
            req = 1'b0;
            if (s_busy) nb++;
            if (s_done) begin
                nd++;
                dp = k;
            end
        end
    endtask

    typedef struct {
        logic        rw;
        logic [3:0]  wsel;
        logic [15:0] d;
        logic [3:0]  rs0;
        logic [3:0]  rs1;
        logic [15:0] e_b0;
        logic [15:0] e_b1;
        logic [15:0] e_n0;
        logic [15:0] e_z0;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, nd, dp;

        tbl[0] = '{1'b1, 4'd5,  16'h1234, 4'd5,  4'd3,  16'h1234, 16'h0000, 16'h0000, 16'h1234};
        tbl[1] = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd5,  16'h1234, 16'h1234, 16'h1234, 16'h1234};
        tbl[2] = '{1'b1, 4'd3,  16'hBEEF, 4'd3,  4'd5,  16'hBEEF, 16'h1234, 16'h0000, 16'hBEEF};
        tbl[3] = '{1'b1, 4'd11, 16'hA5A5, 4'd11, 4'd3,  16'hA5A5, 16'hBEEF, 16'h0000, 16'hA5A5};
        tbl[4] = '{1'b0, 4'd0,  16'h0000, 4'd11, 4'd0,  16'hA5A5, 16'h0000, 16'hA5A5, 16'hA5A5};
        tbl[5] = '{1'b1, 4'd0,  16'h5555, 4'd0,  4'd8,  16'h5555, 16'h0000, 16'h0000, 16'h0000};
        tbl[6] = '{1'b0, 4'd0,  16'h0000, 4'd0,  4'd11, 16'h5555, 16'hA5A5, 16'h5555, 16'h0000};

        rst = 1'b1; d = '0; rw = 1'b0; wsel = '0; rs0 = '0; rs1 = '0; req = 1'b0; op = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        cycle();

        // Directed single-cycle vectors: bypass, delayed visibility, zero R0.
        for (int i = 0; i < 7; i++) begin
            rw = tbl[i].rw; wsel = tbl[i].wsel; d = tbl[i].d;
            rs0 = tbl[i].rs0; rs1 = tbl[i].rs1;
            sample();
            chk($sformatf("tbl%0d_b0", i), 32'(rd_b[15:0]),  32'(tbl[i].e_b0));
            chk($sformatf("tbl%0d_b1", i), 32'(rd_b[31:16]), 32'(tbl[i].e_b1));
            chk($sformatf("tbl%0d_n0", i), 32'(rd_n[15:0]),  32'(tbl[i].e_n0));
            chk($sformatf("tbl%0d_z0", i), 32'(rd_z[15:0]),  32'(tbl[i].e_z0));
            edge_step();
        end

        // Asynchronous reset in mid-cycle clears both banks immediately.
        rw = 1'b0; rs0 = 4'd3; rs1 = 4'd11;
        #2 rst = 1'b1;
        #1;
        chk("arst_r3",  32'(rd_b[15:0]),  32'h0);
        chk("arst_h3",  32'(rd_b[31:16]), 32'h0);
        chk("arst_bsy", {31'd0, busy_b},  32'h0);
        chk("arst_dne", {31'd0, done_b},  32'h0);
        model_reset();
        rst = 1'b0;

        // SAVE with a dropped write to r2 mid-copy.
        for (int i = 0; i < 8; i++) begin
            rw = 1'b1; wsel = 4'(i); d = 16'h0100 + 16'(i);
            cycle();
        end
        rw = 1'b0;
        run_copy(1'b0, 4, 1'b1, 4'd2, 16'hDEAD, 1'b0, nb, nd, dp);
        chk("save_busy", 32'(nb), 32'd9);
        chk("save_done", 32'(nd), 32'd1);
        chk("save_dpos", 32'(dp), 32'd9);
        for (int i = 0; i < 8; i++) begin
            rs0 = 4'(8 + i); rs1 = 4'(i);
            sample();
            chk($sformatf("save_h%0d", i), 32'(rd_b[15:0]),  32'h0100 + 32'(i));
            chk($sformatf("save_r%0d", i), 32'(rd_b[31:16]), 32'h0100 + 32'(i));
            edge_step();
        end

        // Write and request on the same edge: the copy sees the new value.
        rw = 1'b1; wsel = 4'd6; d = 16'h6666;
        run_copy(1'b0, 0, 1'b0, 4'd0, 16'h0, 1'b0, nb, nd, dp);
        chk("simul_done", 32'(nd), 32'd1);
        rs0 = 4'd14; rs1 = 4'd6;
        sample();
        chk("simul_h6", 32'(rd_b[15:0]),  32'h6666);
        chk("simul_r6", 32'(rd_b[31:16]), 32'h6666);
        edge_step();

        // RESTORE with zero R0 and a second request ignored while busy.
        rw = 1'b1; wsel = 4'd8;  d = 16'hFFFF; cycle();
        rw = 1'b1; wsel = 4'd15; d = 16'h7777; cycle();
        rw = 1'b0;
        run_copy(1'b1, 3, 1'b0, 4'd0, 16'h0, 1'b1, nb, nd, dp);
        chk("rest_busy", 32'(nb), 32'd9);
        chk("rest_done", 32'(nd), 32'd1);
        rs0 = 4'd7; rs1 = 4'd0;
        sample();
        chk("rest_z_r7", 32'(rd_z[15:0]),  32'h7777);
        chk("rest_z_r0", 32'(rd_z[31:16]), 32'h0);
        chk("rest_b_r0", 32'(rd_b[31:16]), 32'hFFFF);
        edge_step();

        // Reset while copying word 4, then a clean copy afterwards.
        for (int i = 0; i < 8; i++) begin
            rw = 1'b1; wsel = 4'(i); d = 16'hC000 + 16'(i);
            cycle();
        end
        rw = 1'b0; req = 1'b1; op = 1'b0;
        cycle();
        req = 1'b0;
        repeat (4) cycle();
        rs0 = 4'd4; rs1 = 4'd10;
        #2 rst = 1'b1;
        #1;
        chk("abort_r4",  32'(rd_b[15:0]),  32'h0);
        chk("abort_h2",  32'(rd_b[31:16]), 32'h0);
        chk("abort_bsy", {31'd0, busy_b},  32'h0);
        chk("abort_dne", {31'd0, done_b},  32'h0);
        model_reset();
        rst = 1'b0;
        repeat (3) cycle();
        rw = 1'b1; wsel = 4'd5; d = 16'h0F0F;
        run_copy(1'b0, 0, 1'b0, 4'd0, 16'h0, 1'b0, nb, nd, dp);
        chk("post_busy", 32'(nb), 32'd9);
        chk("post_done", 32'(nd), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rw   = 1'($urandom_range(0, 1));
            wsel = 4'($urandom_range(0, 15));
            d    = 16'($urandom);
            rs0  = ($urandom_range(0, 3) == 0) ? wsel : 4'($urandom_range(0, 15));
            rs1  = 4'($urandom_range(0, 15));
            req  = ($urandom_range(0, 15) == 0);
            op   = 1'($urandom_range(0, 1));
            cycle();
        end
        req = 1'b0; rw = 1'b0;
        repeat (12) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
